// File: rtl/if_id_queue.sv
// IF/ID instruction queue: holds {PC, Instruction} pairs so fetch can run ahead while ID stalls.
// Latency push->head 1 cycle; full (registered) freezes IF, head held under freeze/SRAM_freeze.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           PC_in,
  input  logic [WIDTH-1:0]           Instruction_in,
  input  logic                       freeze,
  input  logic                       SRAM_freeze,
  input  logic                       flush,
  output logic                       full,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           PC_out,
  output logic [WIDTH-1:0]           Instruction_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pop;
  logic               do_push;

  // Status flags come only from registered occupancy, keeping IF's freeze path short.
  assign full      = (count_q == CW'(DEPTH));
  assign valid_out = (count_q != '0);
  assign count     = count_q;

  assign pop     = valid_out & ~freeze & ~SRAM_freeze;
  assign do_push = push & ~full & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are masked by the head gating below.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= {PC_in, Instruction_in};
  end

  // An empty queue presents PC 0 and a NOP instruction.
  assign {PC_out, Instruction_out} = valid_out ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: queue-based reference model checked every cycle, plus literal checks.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             push;
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] Instruction_in;
  logic             freeze;
  logic             SRAM_freeze;
  logic             flush;
  logic             full;
  logic             valid_out;
  logic [WIDTH-1:0] PC_out;
  logic [WIDTH-1:0] Instruction_out;
  logic [2:0]       count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  logic [2*WIDTH-1:0] model_q [$];

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .push(push), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .freeze(freeze), .SRAM_freeze(SRAM_freeze), .flush(flush),
    .full(full), .valid_out(valid_out), .PC_out(PC_out),
    .Instruction_out(Instruction_out), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ideal FIFO of pairs; reset/flush empty it, a pop needs a
  // non-empty queue and no stall, a push needs room.
  always @(posedge clk) begin
    if (rst || flush) begin
      model_q.delete();
    end else begin
      bit do_pop, do_psh;
      do_pop = (model_q.size() != 0) && !freeze && !SRAM_freeze;
      do_psh = push && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_psh) model_q.push_back({PC_in, Instruction_in});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2*WIDTH-1:0] head;
      head = (model_q.size() != 0) ? model_q[0] : '0;
      chk("cyc_count", 32'(count), 32'(model_q.size()));
      chk("cyc_full", 32'(full), 32'(model_q.size() == DEPTH));
      chk("cyc_valid", 32'(valid_out), 32'(model_q.size() != 0));
      chk("cyc_pc", PC_out, head[2*WIDTH-1:WIDTH]);
      chk("cyc_instr", Instruction_out, head[WIDTH-1:0]);
    end
  end

  // Apply one cycle of inputs, then return at the following falling edge.
  task automatic tick(input logic p, input logic [31:0] pc, input logic [31:0] ins,
                      input logic frz, input logic sfrz, input logic fl, input logic r);
    push = p; PC_in = pc; Instruction_in = ins;
    freeze = frz; SRAM_freeze = sfrz; flush = fl; rst = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic frz);
    tick(0, 32'h0, 32'h0, frz, 0, 0, 0);
  endtask

  initial begin
    push = 0; PC_in = '0; Instruction_in = '0;
    freeze = 0; SRAM_freeze = 0; flush = 0; rst = 1;

    // Reset then idle
    tick(0, 0, 0, 0, 0, 0, 1);
    chk_en = 1;
    tick(0, 0, 0, 0, 0, 0, 1);
    idle(0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", PC_out, 32'd0);
    chk("rst_instr", Instruction_out, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // Fill while frozen, overflow push ignored, then drain
    for (int i = 1; i <= 4; i++) tick(1, 32'(4 * i), 32'hE000_0000 | 32'(i), 1, 0, 0, 0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    tick(1, 32'd20, 32'hE000_0005, 1, 0, 0, 0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_head", PC_out, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_pc", PC_out, 32'(4 * i));
      chk("drain_instr", Instruction_out, 32'hE000_0000 | 32'(i));
      idle(0);
    end
    chk("drain_empty", 32'(valid_out), 32'd0);

    // Streaming: head lags input by one cycle, occupancy stays 1
    for (int i = 0; i < 6; i++) begin
      logic [31:0] pc;
      pc = 32'h200 + 32'(4 * i);
      tick(1, pc, pc ^ 32'hA5A5_0000, 0, 0, 0, 0);
      chk("stream_pc", PC_out, pc);
      chk("stream_count", 32'(count), 32'd1);
    end
    idle(0);
    chk("stream_end", 32'(count), 32'd0);

    // Flush with simultaneous push; branch target visible one cycle after it is pushed
    tick(1, 32'h10, 32'h1, 1, 0, 0, 0);
    tick(1, 32'h14, 32'h2, 1, 0, 0, 0);
    tick(1, 32'h18, 32'h3, 1, 0, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd3);
    tick(1, 32'h100, 32'hDEAD_0100, 0, 0, 1, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    tick(1, 32'h300, 32'h0000_0300, 1, 0, 0, 0);
    chk("target_pc", PC_out, 32'h300);
    chk("target_count", 32'(count), 32'd1);
    idle(0);
    chk("target_drain", 32'(valid_out), 32'd0);

    // Wrap-around: 7 pushes interleaved with pops, pointers pass DEPTH
    tick(1, 32'h400, 32'hB0, 1, 0, 0, 0);
    tick(1, 32'h404, 32'hB1, 1, 0, 0, 0);
    tick(1, 32'h408, 32'hB2, 0, 0, 0, 0);
    tick(1, 32'h40C, 32'hB3, 1, 0, 0, 0);
    tick(1, 32'h410, 32'hB4, 0, 0, 0, 0);
    tick(1, 32'h414, 32'hB5, 0, 0, 0, 0);
    tick(1, 32'h418, 32'hB6, 0, 1, 0, 0);
    chk("wrap_count", 32'(count), 32'd4);
    chk("wrap_head", PC_out, 32'h40C);
    chk("wrap_full", 32'(full), 32'd1);
    idle(0);
    chk("wrap_pc1", PC_out, 32'h410);
    idle(0);
    chk("wrap_pc2", PC_out, 32'h414);
    idle(0);
    chk("wrap_pc3", PC_out, 32'h418);
    chk("wrap_instr3", Instruction_out, 32'hB6);
    idle(0);
    chk("wrap_empty", 32'(valid_out), 32'd0);

    // Reset mid-stream behaves as a flush
    tick(1, 32'h500, 32'hC0, 1, 0, 0, 0);
    tick(1, 32'h504, 32'hC1, 1, 0, 0, 0);
    chk("prerst_count", 32'(count), 32'd2);
    tick(1, 32'h508, 32'hC2, 0, 0, 0, 1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pc", PC_out, 32'd0);
    chk("midrst_instr", Instruction_out, 32'd0);
    chk("midrst_full", 32'(full), 32'd0);
    tick(1, 32'h50C, 32'hC3, 0, 0, 0, 0);
    chk("postrst_pc", PC_out, 32'h50C);
    chk("postrst_count", 32'(count), 32'd1);
    idle(0);
    idle(0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# IF_ID_Queue

Instruction queue between IF_Stage and ID_Stage: a small synchronous FIFO that holds fetched {PC, Instruction} pairs, so fetch keeps running while ID is stalled by hazard or SRAM freeze. It replaces the plain IF/ID pipeline register. It also supplies a full flag that IF ORs into its freeze, and discards all queued instructions on a taken branch.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- WIDTH, 32, width of the PC and Instruction fields

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- push  input  1  IF presents a valid fetched pair this cycle
- PC_in  input  WIDTH  PC+4 from IF
- Instruction_in  input  WIDTH  instruction from IF
- freeze  input  1  hazard stall from ID; head is held
- SRAM_freeze  input  1  memory stall; head is held
- flush  input  1  Branch_taken; discards all entries
- full  output  1  count == DEPTH; fed to IF freeze
- valid_out  output  1  queue non-empty; head presented to ID
- PC_out  output  WIDTH  head PC; 0 when empty
- Instruction_out  output  WIDTH  head instruction; 0 (NOP) when empty
- count  output  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH×(2·WIDTH) register array, wr_ptr and rd_ptr of log2(DEPTH) bits, and a count register. Pointers wrap modulo DEPTH by natural overflow.
- pop = valid_out & ~freeze & ~SRAM_freeze.
- do_push = push & ~full & ~flush.
- Priority per cycle: rst > flush > push/pop.
- rst: wr_ptr, rd_ptr and count go to 0. Array contents are don't-care. After reset, outputs are full=0, valid_out=0, PC_out=0, Instruction_out=0, count=0.
- flush: wr_ptr=rd_ptr=0 and count=0 next cycle. Any simultaneous push and pop are ignored, so the wrong-path instruction is not captured.
- do_push only: write array[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- do_push and pop together: write and advance both pointers; count unchanged. This is legal at any occupancy from 1 to DEPTH−1. At count==DEPTH, push is blocked by full, so only the pop takes effect.
- push while full: ignored. No overwrite and no error flag; IF is already frozen by full.
- push while empty: the entry appears on the outputs the next cycle. There is no same-cycle bypass.
- Head outputs are combinational from array[rd_ptr] gated by valid_out. When empty they are forced to 0.
- count never exceeds DEPTH and never underflows. Pop with count==0 cannot occur because pop requires valid_out.

## Timing
- Latency push→visible at ID: 1 cycle.
- full and valid_out are decoded from registered count (full = count==DEPTH, valid_out = count!=0), with no combinational path from push, freeze, SRAM_freeze or flush.
- Sustained throughput: one push and one pop per cycle with no bubbles once count ≥ 1.
- Flush takes effect at the next edge. valid_out=0 in the following cycle, and the branch-target fetch pushed in that cycle is visible one cycle later.
- Reset asserted mid-operation behaves identically to a flush, with priority over every other input in that cycle.
- Freeze held for N cycles keeps the head output stable for N cycles. Pushes continue until full.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then release with push=0. Required: valid_out=0, PC_out=0, Instruction_out=0, count=0, full=0.
- Fill and drain: freeze=1, push pairs PC=4,8,12,16 with Instruction=0xE0000001..4. Required: count=4, full=1 after the 4th edge, and a 5th push is ignored. Release freeze: outputs are PC 4,8,12,16 on consecutive cycles, then valid_out=0.
- Streaming: continuous push with PC incrementing by 4 and no freeze. Required: valid_out=1 from cycle 2, PC_out lags PC_in by 1 cycle, count stays at 1.
- Flush with simultaneous push: count=3, then flush=1 and push=1 with PC=0x100. Required: next cycle count=0 and valid_out=0. PC 0x100 never appears on the outputs.
- Wrap-around: push 7 entries interleaved with pops, so the pointers pass DEPTH. Required: output order equals input order and count matches a reference model every cycle.
- Reset mid-stream: rst pulsed for 1 cycle with count=2, push=1, freeze=0. Required: count=0, all outputs 0, and the first post-reset push appears after 1 cycle.
